// File: rtl/if_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage of the 5-stage MIPS pipeline. This block owns the
//   PC, runs the instruction-memory request/ready handshake, and loads the
//   IF/ID register inputs (PC+4, instruction, valid). It honours stall from
//   hazard detection and PC redirects from ID/EX, and inserts NOP bubbles on
//   a redirect or a memory miss.
//
//   Optional feature: define IF_PERF_COUNT_EN to add the perf_fetch_cnt and
//   perf_bubble_cnt outputs. Both are saturating 32-bit counters.
//
// Ports
//   clk             : single clock, all state updates on posedge
//   reset           : asynchronous, active-low reset
//   stall_i         : hold the PC and outputs; no fetch request is issued
//   redirect_i      : load redirect_pc_i (bits [1:0] cleared) as the next PC
//   redirect_pc_i   : redirect target
//   imem_req_o      : fetch request; the address stays stable while it is high
//   imem_addr_o     : fetch address (PC, or the abandoned address in S_DROP)
//   imem_ready_i    : memory accepts the request; rdata is valid this cycle
//   imem_rdata_i    : fetched instruction word
//   out_PC_4        : PC+4 of the delivered instruction
//   out_Instruction : delivered instruction, or NOP_INSTR for a bubble
//   out_valid       : 1 = real instruction, 0 = bubble
//   perf_fetch_cnt  : (IF_PERF_COUNT_EN) count of normal hits
//   perf_bubble_cnt : (IF_PERF_COUNT_EN) count of cycles that wrote a bubble
// ----------------------------------------------------------------------------
module if_fetch_stage #(
    parameter int               NBits     = 32,
    parameter logic [NBits-1:0] RESET_PC  = 32'h0040_0000,
    parameter logic [NBits-1:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [NBits-1:0] redirect_pc_i,
    output logic             imem_req_o,
    output logic [NBits-1:0] imem_addr_o,
    input  logic             imem_ready_i,
    input  logic [NBits-1:0] imem_rdata_i,
    output logic [NBits-1:0] out_PC_4,
    output logic [NBits-1:0] out_Instruction,
    output logic             out_valid
`ifdef IF_PERF_COUNT_EN
    ,
    output logic [31:0]      perf_fetch_cnt,
    output logic [31:0]      perf_bubble_cnt
`endif
);

    typedef enum logic [1:0] {S_RESET, S_FETCH, S_DROP} state_t;

    state_t           state;
    logic [NBits-1:0] pc;
    logic [NBits-1:0] drop_addr;   // address of the transaction abandoned by a redirect
    logic [NBits-1:0] pc_plus4;
    logic [NBits-1:0] target;
    logic             hit;
    logic             miss;
    logic             bubble_wr;

    assign pc_plus4 = pc + NBits'(4);          // wraps modulo 2^NBits
    assign target   = redirect_pc_i & ~NBits'(3);

    // Request and address are combinational so a stall can pull the request
    // down in the same cycle it is raised.
    always_comb begin
        imem_req_o  = 1'b0;
        imem_addr_o = pc;
        case (state)
            S_FETCH: imem_req_o = !stall_i;
            S_DROP: begin
                imem_req_o  = 1'b1;
                imem_addr_o = drop_addr;
            end
            default: ;
        endcase
    end

    assign hit  = (state == S_FETCH) && imem_req_o &&  imem_ready_i && !redirect_i;
    assign miss = (state == S_FETCH) && imem_req_o && !imem_ready_i && !redirect_i;
    // A redirect beats a stall, so it always writes a bubble. S_DROP writes a
    // bubble every cycle except a plain stall, which holds the outputs.
    assign bubble_wr = ((state != S_RESET) && redirect_i) || miss ||
                       ((state == S_DROP) && !stall_i);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_RESET;
            pc        <= RESET_PC;
            drop_addr <= RESET_PC;
        end else begin
            case (state)
                S_RESET: state <= S_FETCH;
                S_FETCH: begin
                    if (redirect_i) begin
                        pc <= target;
                        // An in-flight request must still be completed at
                        // its old address; its data is thrown away.
                        if (imem_req_o && !imem_ready_i) begin
                            state     <= S_DROP;
                            drop_addr <= pc;
                        end
                    end else if (hit) begin
                        pc <= pc_plus4;
                    end
                end
                S_DROP: begin
                    if (redirect_i) pc <= target;
                    if (imem_ready_i) state <= S_FETCH;
                end
                default: state <= S_RESET;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_PC_4        <= '0;
            out_Instruction <= NOP_INSTR;
            out_valid       <= 1'b0;
        end else if (bubble_wr) begin
            // out_PC_4 keeps the last delivered value across bubbles.
            out_Instruction <= NOP_INSTR;
            out_valid       <= 1'b0;
        end else if (hit) begin
            out_PC_4        <= pc_plus4;
            out_Instruction <= imem_rdata_i;
            out_valid       <= 1'b1;
        end
    end

`ifdef IF_PERF_COUNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetch_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (hit && (perf_fetch_cnt != 32'hFFFF_FFFF))
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (bubble_wr && (perf_bubble_cnt != 32'hFFFF_FFFF))
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_stage
//   Directed bench for if_fetch_stage. The stimulus task drives one cycle at a
//   time and checks the request and address. When the cycle is a hit, the task
//   pushes the expected {PC+4, instruction} into a scoreboard queue. A
//   separate monitor process pops the queue and compares it whenever the stage
//   presents a newly delivered valid instruction. The memory returns a word
//   derived from its address, so every delivery is distinct.
// ----------------------------------------------------------------------------
module tb_if_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i = 1'b1;
    logic [31:0] imem_rdata_i;
    logic [31:0] out_PC_4;
    logic [31:0] out_Instruction;
    logic        out_valid;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5A5, a[15:0]};
    endfunction

    assign imem_rdata_i = mem(imem_addr_o);

    if_fetch_stage dut (
        .clk(clk), .reset(reset), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o),
        .imem_addr_o(imem_addr_o), .imem_ready_i(imem_ready_i),
        .imem_rdata_i(imem_rdata_i), .out_PC_4(out_PC_4),
        .out_Instruction(out_Instruction), .out_valid(out_valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},   {31'd0, imem_req_o}, 32'd0);
        chk({tag, "_addr"},  imem_addr_o, RST_PC);
        chk({tag, "_pc4"},   out_PC_4, 32'd0);
        chk({tag, "_instr"}, out_Instruction, NOP);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    endtask

    // One cycle: drive the inputs at negedge, then check req/addr and, when
    // asked, that the registered outputs currently show a bubble.
    task automatic cyc(input logic st, input logic rd, input logic [31:0] rpc,
                       input logic rdy, input logic exp_req, input logic [31:0] exp_addr,
                       input bit push, input bit bub);
        @(negedge clk);
        stall_i = st; redirect_i = rd; redirect_pc_i = rpc; imem_ready_i = rdy;
        #1;
        chk("req", {31'd0, imem_req_o}, {31'd0, exp_req});
        chk("addr", imem_addr_o, exp_addr);
        if (bub) begin
            chk("bubble_valid", {31'd0, out_valid}, 32'd0);
            chk("bubble_instr", out_Instruction, NOP);
        end
        if (push) sb.push_back({exp_addr + 32'd4, mem(exp_addr)});
    endtask

    // Monitor: one pop per new valid delivery. Outputs held by a stall look
    // identical, so they are not counted twice.
    bit          have_last = 0;
    logic [63:0] last_out;
    always @(negedge clk) begin
        if (reset && out_valid) begin
            if (!have_last || last_out !== {out_PC_4, out_Instruction}) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL deliver_unexpected: got pc4=%h instr=%h, scoreboard empty", out_PC_4, out_Instruction);
                end else begin
                    logic [63:0] e;
                    e = sb.pop_front();
                    if (e !== {out_PC_4, out_Instruction}) begin
                        errors++;
                        $display("FAIL deliver: got pc4=%h instr=%h expected pc4=%h instr=%h",
                                 out_PC_4, out_Instruction, e[63:32], e[31:0]);
                    end
                end
                last_out  = {out_PC_4, out_Instruction};
                have_last = 1;
            end
        end else begin
            have_last = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset for 3 clocks, then zero-wait fetch stream.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b1;
        #1 chk("sreset_req", {31'd0, imem_req_o}, 32'd0);
        cyc(0, 0, 0, 1, 1, 32'h0040_0000, 1, 1);
        cyc(0, 0, 0, 1, 1, 32'h0040_0004, 1, 0);
        // 2: two wait states at 0x00400008.
        cyc(0, 0, 0, 0, 1, 32'h0040_0008, 0, 0);
        cyc(0, 0, 0, 0, 1, 32'h0040_0008, 0, 1);
        cyc(0, 0, 0, 1, 1, 32'h0040_0008, 1, 1);
        cyc(0, 0, 0, 1, 1, 32'h0040_000C, 1, 0);
        // 3: stall for 3 clocks, then resume at the same address.
        repeat (3) cyc(1, 0, 0, 1, 0, 32'h0040_0010, 0, 0);
        cyc(0, 0, 0, 1, 1, 32'h0040_0010, 1, 0);
        cyc(0, 0, 0, 1, 1, 32'h0040_0014, 1, 0);
        // 4: redirect while memory is waiting -> drop the old transaction.
        cyc(0, 0, 0, 0, 1, 32'h0040_0018, 0, 0);
        cyc(0, 1, 32'h0040_0103, 0, 1, 32'h0040_0018, 0, 1);
        cyc(0, 0, 0, 0, 1, 32'h0040_0018, 0, 1);
        cyc(0, 0, 0, 1, 1, 32'h0040_0018, 0, 1);
        cyc(0, 0, 0, 1, 1, 32'h0040_0100, 1, 1);
        cyc(0, 0, 0, 1, 1, 32'h0040_0104, 1, 0);
        // 5: redirect and stall together; then wrap from 0xFFFFFFFC to 0.
        cyc(1, 1, 32'hFFFF_FFFC, 1, 0, 32'h0040_0108, 0, 0);
        cyc(0, 0, 0, 1, 1, 32'hFFFF_FFFC, 1, 1);
        cyc(0, 0, 0, 1, 1, 32'h0000_0000, 1, 0);
        // 6: reset asserted while the request is pending.
        cyc(0, 0, 0, 0, 1, 32'h0000_0004, 0, 0);
        @(negedge clk);
        #1;
        chk("pend_req", {31'd0, imem_req_o}, 32'd1);
        chk("pend_valid", {31'd0, out_valid}, 32'd0);
        #2 reset = 1'b0;
        #1 chk_reset_vals("async_rst");
        @(negedge clk);
        reset = 1'b1; imem_ready_i = 1'b1;
        cyc(0, 0, 0, 1, 1, 32'h0040_0000, 1, 1);
        cyc(0, 0, 0, 1, 1, 32'h0040_0004, 1, 0);
        cyc(1, 0, 0, 1, 0, 32'h0040_0008, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
